// File: rtl/pcm_frame_packer.sv
// Packs channel-interleaved PCM samples into NUM_CH-wide words with TLAST framing and a 2-word skid FIFO.
// Optional PCM_PACKER_DROP_EN: never stall the source; drop completed words when the FIFO is full.
module pcm_frame_packer #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int NUM_CH       = 2,
    parameter int FRAME_LEN    = 1024
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [SAMPLE_WIDTH-1:0]        stream_in_TDATA,
    input  logic                           stream_in_TVALID,
    output logic                           stream_in_TREADY,
    input  logic                           stream_in_TUSER,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] stream_out_TDATA,
    output logic                           stream_out_TVALID,
    input  logic                           stream_out_TREADY,
    output logic                           stream_out_TLAST,
    output logic [31:0]                    frame_count,
    output logic                           align_err
`ifdef PCM_PACKER_DROP_EN
    ,
    output logic [15:0]                    drop_count
`endif
);

    localparam int DATA_WIDTH = NUM_CH * SAMPLE_WIDTH;
    localparam int LW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int LAST_IDX   = NUM_CH - 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_CH - 1);
    localparam logic [FW-1:0] LAST_WORD = FW'(FRAME_LEN - 1);

    logic [LW-1:0]         lane_q, lane_d;
    logic [FW-1:0]         wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] part_q, part_d;
    logic [DATA_WIDTH-1:0] mem_data_q [2];
    logic [DATA_WIDTH-1:0] mem_data_d [2];
    logic                  mem_last_q [2];
    logic                  mem_last_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [31:0]           frame_count_q, frame_count_d;
    logic                  align_err_q, align_err_d;

    logic                  in_ready;
    logic                  in_fire;
    logic                  out_fire;
    logic                  resync;
    logic                  complete;
    logic                  push;
    logic                  word_last;
    logic [DATA_WIDTH-1:0] full_word;

`ifdef PCM_PACKER_DROP_EN
    logic [15:0]           drop_count_q, drop_count_d;
    logic                  drop;
`endif

    always_comb begin
        // Ready is gated by the reset pin itself so it is low for the whole reset window.
`ifdef PCM_PACKER_DROP_EN
        in_ready = ap_rst_n;
`else
        in_ready = ap_rst_n && !((lane_q == LAST_LANE) && (count_q == 2'd2));
`endif
        in_fire   = stream_in_TVALID && in_ready;
        out_fire  = (count_q != 2'd0) && stream_out_TREADY;
        resync    = stream_in_TUSER && (lane_q != '0);
        complete  = in_fire && !resync && (lane_q == LAST_LANE);
        word_last = (wcnt_q == LAST_WORD);

        full_word = part_q;
        full_word[LAST_IDX*SAMPLE_WIDTH +: SAMPLE_WIDTH] = stream_in_TDATA;

`ifdef PCM_PACKER_DROP_EN
        push = complete && !((count_q == 2'd2) && !out_fire);
        drop = complete && !push;
`else
        push = complete;
`endif

        part_d = part_q;
        lane_d = lane_q;
        if (in_fire) begin
            if (resync) begin
                part_d[SAMPLE_WIDTH-1:0] = stream_in_TDATA;
                lane_d = LW'(1);
            end else if (lane_q == LAST_LANE) begin
                lane_d = '0;
            end else begin
                part_d[int'(lane_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = stream_in_TDATA;
                lane_d = lane_q + LW'(1);
            end
        end

        // Dropped words still consume a frame slot so TLAST stays on the source's frame grid.
        wcnt_d = wcnt_q;
        if (complete) begin
            wcnt_d = word_last ? '0 : wcnt_q + FW'(1);
        end

        mem_data_d = mem_data_q;
        mem_last_d = mem_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = full_word;
            mem_last_d[wr_ptr_q] = word_last;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (out_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, out_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        frame_count_d = frame_count_q;
        if (out_fire && mem_last_q[rd_ptr_q]) begin
            frame_count_d = frame_count_q + 32'd1;
        end

        align_err_d = in_fire && resync;

`ifdef PCM_PACKER_DROP_EN
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lane_q        <= '0;
            wcnt_q        <= '0;
            part_q        <= '0;
            mem_data_q    <= '{default: '0};
            mem_last_q    <= '{default: 1'b0};
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            frame_count_q <= 32'd0;
            align_err_q   <= 1'b0;
        end else begin
            lane_q        <= lane_d;
            wcnt_q        <= wcnt_d;
            part_q        <= part_d;
            mem_data_q    <= mem_data_d;
            mem_last_q    <= mem_last_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            frame_count_q <= frame_count_d;
            align_err_q   <= align_err_d;
        end
    end

`ifdef PCM_PACKER_DROP_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign stream_in_TREADY  = in_ready;
    assign stream_out_TVALID = (count_q != 2'd0);
    assign stream_out_TDATA  = mem_data_q[rd_ptr_q];
    assign stream_out_TLAST  = mem_last_q[rd_ptr_q] && (count_q != 2'd0);
    assign frame_count       = frame_count_q;
    assign align_err         = align_err_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Directed bench for pcm_frame_packer (NUM_CH=2, FRAME_LEN=4) with a queue-based reference model.
module tb_pcm_frame_packer;

    localparam int SW = 32;
    localparam int NCH = 2;
    localparam int FLEN = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [SW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_user;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [31:0]   frame_count;
    logic          align_err;
`ifdef PCM_PACKER_DROP_EN
    logic [15:0]   drop_count;
`endif

    int total = 0;
    int bad = 0;
    int align_seen = 0;

    // model state: pending output words {last,data}, partial samples, word index
    logic [64:0] mq [$];
    logic [64:0] lg [$];
    logic [SW-1:0] m_part [NCH];
    int          m_lane;
    int          m_widx;
    logic [31:0] m_frames;
    logic        m_align;
    int          m_drops;

    pcm_frame_packer #(.SAMPLE_WIDTH(SW), .NUM_CH(NCH), .FRAME_LEN(FLEN)) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .stream_in_TDATA   (in_data),
        .stream_in_TVALID  (in_valid),
        .stream_in_TREADY  (in_ready),
        .stream_in_TUSER   (in_user),
        .stream_out_TDATA  (out_data),
        .stream_out_TVALID (out_valid),
        .stream_out_TREADY (out_ready),
        .stream_out_TLAST  (out_last),
        .frame_count       (frame_count),
        .align_err         (align_err)
`ifdef PCM_PACKER_DROP_EN
        ,
        .drop_count        (drop_count)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [64:0] exp);
        total++;
        if (idx >= lg.size()) begin
            bad++;
            $display("FAIL %s actual=<no word %0d> required=%h", name, idx, exp);
        end else if (lg[idx] !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, lg[idx], exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NCH; i++) m_part[i] = '0;
        m_lane = 0;
        m_widx = 0;
        m_frames = 0;
        m_align = 1'b0;
        m_drops = 0;
    endtask

    initial model_reset();

    // Single compare process: check current outputs, then apply the coming edge to the model.
    always @(negedge ap_clk) begin
        logic exp_ready;
        logic pop;
        logic [64:0] w;
        if (!ap_rst_n) begin
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_last", {63'd0, out_last}, 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_frame_count", {32'd0, frame_count}, 64'd0);
            chk("rst_align_err", {63'd0, align_err}, 64'd0);
`ifdef PCM_PACKER_DROP_EN
            chk("rst_drop_count", {48'd0, drop_count}, 64'd0);
`endif
            model_reset();
        end else begin
`ifdef PCM_PACKER_DROP_EN
            exp_ready = 1'b1;
`else
            exp_ready = !((m_lane == NCH - 1) && (mq.size() == 2));
`endif
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
            chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("out_data", out_data, mq[0][63:0]);
                chk("out_last", {63'd0, out_last}, {63'd0, mq[0][64]});
            end
            chk("frame_count", {32'd0, frame_count}, {32'd0, m_frames});
            chk("align_err", {63'd0, align_err}, {63'd0, m_align});
`ifdef PCM_PACKER_DROP_EN
            chk("drop_count", {48'd0, drop_count}, 64'(m_drops));
`endif
            if (align_err) align_seen++;

            pop = (mq.size() != 0) && out_ready;
            if (pop) begin
                lg.push_back({out_last, out_data});
                if (mq[0][64]) m_frames++;
                void'(mq.pop_front());
            end
            m_align = 1'b0;
            if (in_valid && exp_ready) begin
                if (in_user && m_lane != 0) begin
                    m_part[0] = in_data;
                    m_lane = 1;
                    m_align = 1'b1;
                end else begin
                    m_part[m_lane] = in_data;
                    if (m_lane == NCH - 1) begin
                        w = {(m_widx == FLEN - 1), m_part[1], m_part[0]};
                        m_widx = (m_widx + 1) % FLEN;
                        if (mq.size() < 2) mq.push_back(w);
                        else if (m_drops < 16'hFFFF) m_drops++;
                        m_lane = 0;
                    end else begin
                        m_lane++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [SW-1:0] d, input logic u);
        int n;
        logic acc;
        in_valid = 1'b1;
        in_data = d;
        in_user = u;
        n = 0;
        do begin
            @(negedge ap_clk);
            acc = in_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=accepted data=%h", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic word(input logic [SW-1:0] a, input logic [SW-1:0] b);
        send(a, 1'b1);
        send(b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        idle(3);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_user = 1'b0;
        out_ready = 1'b1;
        idle(3);
        ap_rst_n = 1'b1;

        // basic packing and one-cycle latency
        base = lg.size();
        send(32'h11, 1'b1);
        send(32'h22, 1'b0);
        send(32'h33, 1'b1);
        send(32'h44, 1'b0);
        idle(4);
        chk_log("pack_w0", base, {1'b0, 64'h00000022_00000011});
        chk_log("pack_w1", base + 1, {1'b0, 64'h00000044_00000033});

        // eight words from a clean start: TLAST on 4th and 8th
        pulse_reset();
        base = lg.size();
        align_seen = 0;
        for (int i = 0; i < 8; i++) word(32'h100 + 2 * i, 32'h101 + 2 * i);
        idle(4);
        chk_log("frame_w3", base + 3, {1'b1, 64'h00000107_00000106});
        chk_log("frame_w4", base + 4, {1'b0, 64'h00000109_00000108});
        chk_log("frame_w7", base + 7, {1'b1, 64'h0000010F_0000010E});
        chk("frame_count_2", {32'd0, frame_count}, 64'd2);
        chk("no_align_err", 64'(align_seen), 64'd0);

        // resync: A discarded, word {C,B}, single-cycle align_err
        base = lg.size();
        align_seen = 0;
        send(32'hA, 1'b1);
        send(32'hB, 1'b1);
        send(32'hC, 1'b0);
        idle(4);
        chk_log("resync_word", base, {1'b0, 64'h0000000C_0000000B});
        chk("align_pulses", 64'(align_seen), 64'd1);

        base = lg.size();
`ifdef PCM_PACKER_DROP_EN
        // full FIFO drops words but keeps the frame grid
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) word(32'h301 + 2 * i, 32'h302 + 2 * i);
        idle(1);
        chk("drop_count_3", {48'd0, drop_count}, 64'd3);
        out_ready = 1'b1;
        idle(4);
        word(32'h311, 32'h312);
        word(32'h313, 32'h314);
        idle(4);
        chk_log("drop_keep0", base, {1'b0, 64'h00000302_00000301});
        chk_log("drop_keep1", base + 1, {1'b0, 64'h00000304_00000303});
        chk_log("drop_after0", base + 2, {1'b0, 64'h00000312_00000311});
        chk_log("drop_after1", base + 3, {1'b1, 64'h00000314_00000313});
`else
        // backpressure: two buffered, third stalls on its last lane
        out_ready = 1'b0;
        fork
            begin
                word(32'h201, 32'h202);
                word(32'h203, 32'h204);
                word(32'h205, 32'h206);
            end
            begin
                repeat (8) @(negedge ap_clk);
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
                @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(6);
        chk_log("bp_w0", base, {1'b0, 64'h00000202_00000201});
        chk_log("bp_w1", base + 1, {1'b0, 64'h00000204_00000203});
        chk_log("bp_w2", base + 2, {1'b1, 64'h00000206_00000205});
`endif
        chk("frame_count_3", {32'd0, frame_count}, 64'd3);

        // reset mid-frame and mid-word
        word(32'h401, 32'h402);
        send(32'h403, 1'b1);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_frame_count", {32'd0, frame_count}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        idle(2);
        ap_rst_n = 1'b1;
        base = lg.size();
        for (int i = 0; i < 4; i++) word(32'h501 + 2 * i, 32'h502 + 2 * i);
        idle(4);
        chk_log("post_rst_w0", base, {1'b0, 64'h00000502_00000501});
        chk_log("post_rst_w3", base + 3, {1'b1, 64'h00000508_00000507});
        chk("post_rst_frames", {32'd0, frame_count}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
